// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush sequencer
// and the datapath top that consumes its stage controls.
package pipeline_pkg;

  // Sequencer states; the controller keeps legacy-style constants built from these.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  // Per-stage register enables, NOP strobes and PC redirect select.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic pc_sel_redirect;
  } stage_ctrl_t;

  // Opcode of BEQ (branch class), used by the datapath branch decode.
  localparam logic [6:0] BEQ_OP = 7'b1100011;

  // Whole pipeline frozen, nothing flushed.
  localparam stage_ctrl_t CTRL_HOLD = '0;

  // Normal flow: every stage advances.
  localparam stage_ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                       ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                       pc_sel_redirect: 1'b0};

  // Mispredict recovery: take corrected target, squash IF/ID and ID/EX.
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                            pc_sel_redirect: 1'b1};

  // Load-use: hold PC and IF/ID, insert a bubble into ID/EX, drain the rest.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                            pc_sel_redirect: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory requests in, stage controls and status out.
// The controller is the slave; the pipeline side (or a bench) is the master.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             LOAD_USE_STALL;
  logic             BEQ_WRONG_PRED;
  logic             DMEM_REQ;
  logic             DMEM_READY;
  logic             PC_EN;
  logic             IF_ID_EN;
  logic             ID_EX_EN;
  logic             EX_MEM_EN;
  logic             MEM_WB_EN;
  logic             IF_ID_FLUSH;
  logic             ID_EX_FLUSH;
  logic             PC_SEL_REDIRECT;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;
  logic             MEM_TIMEOUT_ERR;

  modport master (
    output LOAD_USE_STALL, BEQ_WRONG_PRED, DMEM_REQ, DMEM_READY,
    input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
    input  IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL_REDIRECT,
    input  STALL_CNT, FLUSH_CNT, MEM_TIMEOUT_ERR
  );

  modport slave (
    input  LOAD_USE_STALL, BEQ_WRONG_PRED, DMEM_REQ, DMEM_READY,
    output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
    output IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL_REDIRECT,
    output STALL_CNT, FLUSH_CNT, MEM_TIMEOUT_ERR
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count on i_inc until all-ones; synchronous clear wins over increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, BEQ
// mispredict and data-memory wait into stage controls, with a memory-wait
// watchdog and saturating stall/flush counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RST,
  pipeline_ctrl_if.slave     bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_ERROR    = ERROR;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic              w_redirect;
  stage_ctrl_t       w_ctrl_raw;
  stage_ctrl_t       w_ctrl;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [CNT_W-1:0]  w_flush_cnt;

  assign w_wait_inc = r_wait_cnt + 1'b1;
  // A mispredict seen during the wait, or on the completing cycle itself, is replayed on release.
  assign w_redirect = r_pending | bus.BEQ_WRONG_PRED;

  // Next-state, stage controls and counter strobes from state + requests.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_ctrl_raw    = CTRL_HOLD;
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_wait_nxt    = r_wait_cnt;
    w_err_nxt     = r_err;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (bus.DMEM_REQ && !bus.DMEM_READY) begin
          // Freeze; remember a mispredict so it is not lost while frozen.
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
          if (bus.BEQ_WRONG_PRED) w_pending_nxt = 1'b1;
        end else if (bus.BEQ_WRONG_PRED) begin
          // The dependent instruction gets squashed, so load-use is moot.
          w_ctrl_raw  = CTRL_REDIRECT;
          w_flush_inc = 1'b1;
        end else if (bus.LOAD_USE_STALL) begin
          w_ctrl_raw  = CTRL_LOAD_USE;
          w_stall_inc = 1'b1;
        end else begin
          w_ctrl_raw = CTRL_RUN;
        end
      end
      ST_MEM_WAIT: begin
        w_stall_inc = 1'b1;
        if (bus.DMEM_READY) begin
          // Release in the completing cycle, including the exact TIMEOUT cycle.
          w_ctrl_raw    = w_redirect ? CTRL_REDIRECT : CTRL_RUN;
          w_flush_inc   = w_redirect;
          w_pending_nxt = 1'b0;
          w_wait_nxt    = '0;
          w_state_nxt   = ST_RUN;
        end else begin
          w_pending_nxt = w_redirect;
          w_wait_nxt    = w_wait_inc;
          if (w_wait_inc == TIMEOUT_V) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        w_ctrl_raw = CTRL_HOLD;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Controls are forced inactive for as long as reset is held.
  assign w_ctrl = RST ? CTRL_HOLD : w_ctrl_raw;

  // Sequencer state, pending redirect, wait counter and sticky error.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (RST) begin
      r_state    <= ST_RUN;
      r_pending  <= 1'b0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_stall_inc),
    .i_clr (1'b0),
    .o_cnt (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_flush_inc),
    .i_clr (1'b0),
    .o_cnt (w_flush_cnt)
  );

  assign bus.PC_EN           = w_ctrl.pc_en;
  assign bus.IF_ID_EN        = w_ctrl.if_id_en;
  assign bus.ID_EX_EN        = w_ctrl.id_ex_en;
  assign bus.EX_MEM_EN       = w_ctrl.ex_mem_en;
  assign bus.MEM_WB_EN       = w_ctrl.mem_wb_en;
  assign bus.IF_ID_FLUSH     = w_ctrl.if_id_flush;
  assign bus.ID_EX_FLUSH     = w_ctrl.id_ex_flush;
  assign bus.PC_SEL_REDIRECT = w_ctrl.pc_sel_redirect;
  assign bus.STALL_CNT       = w_stall_cnt;
  assign bus.FLUSH_CNT       = w_flush_cnt;
  assign bus.MEM_TIMEOUT_ERR = r_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default sizing and CNT_W=4/TIMEOUT=8)
// share one directed stimulus stream; a behavioural model checks both every cycle,
// and literal expectations pin the key scenarios.
module tb_pipeline_ctrl;

  // Expected control vectors, ordered {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN,
  // MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL_REDIRECT}.
  localparam logic [7:0] E_HOLD  = 8'b0000_0000;
  localparam logic [7:0] E_RUN   = 8'b1111_1000;
  localparam logic [7:0] E_LU    = 8'b0011_1010;
  localparam logic [7:0] E_REDIR = 8'b1111_1111;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  logic tb_lu = 1'b0, tb_beq = 1'b0, tb_req = 1'b0, tb_rdy = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_ctrl_if #(.CNT_W(4))  if1 ();

  assign if0.LOAD_USE_STALL = tb_lu;
  assign if0.BEQ_WRONG_PRED = tb_beq;
  assign if0.DMEM_REQ       = tb_req;
  assign if0.DMEM_READY     = tb_rdy;
  assign if1.LOAD_USE_STALL = tb_lu;
  assign if1.BEQ_WRONG_PRED = tb_beq;
  assign if1.DMEM_REQ       = tb_req;
  assign if1.DMEM_READY     = tb_rdy;

  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(64)) dut0 (.CLK(clk), .RST(tb_rst), .bus(if0.slave));
  pipeline_ctrl #(.CNT_W(4),  .TIMEOUT(8))  dut1 (.CLK(clk), .RST(tb_rst), .bus(if1.slave));

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int ctrl_of(input int i);
    if (i == 0)
      return int'({if0.PC_EN, if0.IF_ID_EN, if0.ID_EX_EN, if0.EX_MEM_EN, if0.MEM_WB_EN,
                   if0.IF_ID_FLUSH, if0.ID_EX_FLUSH, if0.PC_SEL_REDIRECT});
    return int'({if1.PC_EN, if1.IF_ID_EN, if1.ID_EX_EN, if1.EX_MEM_EN, if1.MEM_WB_EN,
                 if1.IF_ID_FLUSH, if1.ID_EX_FLUSH, if1.PC_SEL_REDIRECT});
  endfunction

  function automatic int stall_of(input int i);
    return (i == 0) ? int'(if0.STALL_CNT) : int'(if1.STALL_CNT);
  endfunction

  function automatic int flush_of(input int i);
    return (i == 0) ? int'(if0.FLUSH_CNT) : int'(if1.FLUSH_CNT);
  endfunction

  function automatic int err_of(input int i);
    return (i == 0) ? int'(if0.MEM_TIMEOUT_ERR) : int'(if1.MEM_TIMEOUT_ERR);
  endfunction

  // Behavioural model: "waiting" / "dead" modes, elapsed wait cycles, counters as ints.
  int lim_timeout [2] = '{64, 8};
  int cnt_max     [2] = '{65535, 15};
  bit m_waiting [2];
  bit m_dead    [2];
  bit m_pend    [2];
  int m_waited  [2];
  int m_stall   [2];
  int m_flush   [2];

  // Compare both DUTs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] exp_ctrl;
      if (tb_rst) begin
        m_waiting[i] = 1'b0; m_dead[i] = 1'b0; m_pend[i] = 1'b0;
        m_waited[i]  = 0;    m_stall[i] = 0;   m_flush[i] = 0;
      end
      check($sformatf("dut%0d stall_cnt", i), stall_of(i), m_stall[i]);
      check($sformatf("dut%0d flush_cnt", i), flush_of(i), m_flush[i]);
      check($sformatf("dut%0d timeout_err", i), err_of(i), int'(m_dead[i]));
      exp_ctrl = E_HOLD;
      if (tb_rst || m_dead[i]) begin
        exp_ctrl = E_HOLD;
      end else if (m_waiting[i]) begin
        if (m_stall[i] < cnt_max[i]) m_stall[i]++;
        if (tb_rdy) begin
          exp_ctrl = (m_pend[i] || tb_beq) ? E_REDIR : E_RUN;
          if ((m_pend[i] || tb_beq) && m_flush[i] < cnt_max[i]) m_flush[i]++;
          m_pend[i]    = 1'b0;
          m_waiting[i] = 1'b0;
        end else begin
          if (tb_beq) m_pend[i] = 1'b1;
          m_waited[i]++;
          if (m_waited[i] >= lim_timeout[i]) begin
            m_dead[i]    = 1'b1;
            m_waiting[i] = 1'b0;
          end
        end
      end else if (tb_req && !tb_rdy) begin
        m_waiting[i] = 1'b1;
        m_waited[i]  = 1;
        m_pend[i]    = tb_beq;
      end else if (tb_beq) begin
        exp_ctrl = E_REDIR;
        if (m_flush[i] < cnt_max[i]) m_flush[i]++;
      end else if (tb_lu) begin
        exp_ctrl = E_LU;
        if (m_stall[i] < cnt_max[i]) m_stall[i]++;
      end else begin
        exp_ctrl = E_RUN;
      end
      check($sformatf("dut%0d ctrl", i), ctrl_of(i), int'(exp_ctrl));
    end
  end

  // One clock cycle of stimulus; returns just after the mid-cycle compare.
  task automatic step(input logic rst, input logic lu, input logic beq,
                      input logic req, input logic rdy);
    @(posedge clk);
    #1;
    tb_rst = rst; tb_lu = lu; tb_beq = beq; tb_req = req; tb_rdy = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held 3 cycles, then idle.
    repeat (3) step(1, 0, 0, 0, 0);
    check("reset ctrl dut0", ctrl_of(0), int'(E_HOLD));
    check("reset ctrl dut1", ctrl_of(1), int'(E_HOLD));
    step(0, 0, 0, 0, 0);
    check("first post-reset ctrl", ctrl_of(0), int'(E_RUN));
    repeat (2) step(0, 0, 0, 0, 0);
    check("idle stall_cnt", stall_of(0), 0);

    // Single load-use cycle.
    step(0, 1, 0, 0, 0);
    check("load-use ctrl", ctrl_of(0), int'(E_LU));
    step(0, 0, 0, 0, 0);
    check("load-use stall_cnt", stall_of(0), 1);
    check("after load-use ctrl", ctrl_of(0), int'(E_RUN));

    // Mispredict and load-use together: redirect wins.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("mispred+lu ctrl", ctrl_of(0), int'(E_REDIR));
    step(0, 0, 0, 0, 0);
    check("mispred+lu flush_cnt", flush_of(0), 1);
    check("mispred+lu stall_cnt", stall_of(0), 0);

    // Four frozen cycles with a mispredict buried in the second, then ready.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("wait c1 ctrl", ctrl_of(0), int'(E_HOLD));
    step(0, 0, 1, 1, 0);
    check("wait c2 ctrl", ctrl_of(0), int'(E_HOLD));
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("wait c4 ctrl", ctrl_of(0), int'(E_HOLD));
    step(0, 0, 0, 1, 1);
    check("wait release ctrl", ctrl_of(0), int'(E_REDIR));
    step(0, 0, 0, 0, 0);
    check("wait stall_cnt", stall_of(0), 4);
    check("wait flush_cnt", flush_of(0), 1);
    check("back in RUN ctrl", ctrl_of(0), int'(E_RUN));

    // Zero-wait accesses never stall.
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 1);
    check("zero-wait ctrl", ctrl_of(0), int'(E_RUN));
    check("zero-wait stall_cnt", stall_of(0), 0);

    // Watchdog on dut1 (TIMEOUT=8); dut0 keeps waiting.
    step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    check("watchdog err before", err_of(1), 0);
    step(0, 0, 0, 1, 0);
    check("watchdog err raised", err_of(1), 1);
    check("watchdog stall_cnt", stall_of(1), 7);
    repeat (19) step(0, 0, 0, 1, 0);
    check("watchdog ctrl frozen", ctrl_of(1), int'(E_HOLD));
    check("no err at TIMEOUT=64", err_of(0), 0);
    step(0, 0, 0, 0, 1);
    check("error state ignores ready", ctrl_of(1), int'(E_HOLD));
    step(1, 0, 0, 0, 0);
    check("reset clears err", err_of(1), 0);
    step(0, 0, 0, 0, 0);
    check("reset restores RUN", ctrl_of(1), int'(E_RUN));

    // Reset mid-wait drops the pending redirect.
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check("no stale redirect", ctrl_of(0), int'(E_RUN));
    step(0, 0, 0, 0, 0);
    check("no stale flush_cnt", flush_of(0), 0);

    // Saturation: 20 load-use cycles.
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("saturated stall_cnt dut1", stall_of(1), 15);
    check("unsaturated stall_cnt dut0", stall_of(0), 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges the load-use hazard request, the EX-stage BEQ misprediction and data-memory wait handshakes into per-stage register enables, bubble/flush strobes and a PC redirect select. It also keeps stall/flush performance counters and a memory-wait watchdog. It sits between hazard_unit, the branch-resolve logic in EX, the data-memory port and all pipeline registers.

Parameters:
CNT_W, 16, width of the performance counters (saturating)
TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before the error state

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
LOAD_USE_STALL  in  1  load-use request from hazard_unit (its STALL)
BEQ_WRONG_PRED  in  1  misprediction resolved in EX this cycle
DMEM_REQ  in  1  MEM stage holds a load/store this cycle
DMEM_READY  in  1  data memory completes the access this cycle
PC_EN  out  1  PC register write enable
IF_ID_EN  out  1  IF/ID register enable
ID_EX_EN  out  1  ID/EX register enable
EX_MEM_EN  out  1  EX/MEM register enable
MEM_WB_EN  out  1  MEM/WB register enable
IF_ID_FLUSH  out  1  load NOP into IF/ID
ID_EX_FLUSH  out  1  load NOP (bubble) into ID/EX
PC_SEL_REDIRECT  out  1  PC mux selects the EX-computed corrected target
STALL_CNT  out  CNT_W  cycles lost to load-use or memory wait
FLUSH_CNT  out  CNT_W  number of redirects applied
MEM_TIMEOUT_ERR  out  1  sticky watchdog error

Behaviour:
- All controls are combinational from state + inputs, valid in the same cycle. The FSM, pending flag, counters and error bit are registered on CLK.
- RST high: state=RUN, redirect_pending=0, wait_cnt=0, STALL_CNT=FLUSH_CNT=0, MEM_TIMEOUT_ERR=0. All enables, flushes and PC_SEL_REDIRECT are forced 0 while RST is high. The first enables appear in the cycle after RST is released. RST mid-wait discards any pending redirect.
- States: RUN, MEM_WAIT, ERROR.
- RUN, priority order:
  1. DMEM_REQ & !DMEM_READY: all five enables 0, go to MEM_WAIT, wait_cnt=1. A BEQ_WRONG_PRED in the same cycle sets redirect_pending=1 and takes no other action.
  2. Otherwise, BEQ_WRONG_PRED: all enables 1, PC_SEL_REDIRECT=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FLUSH_CNT+1. LOAD_USE_STALL is ignored because the dependent instruction is squashed.
  3. Otherwise, LOAD_USE_STALL: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, ID_EX_EN/EX_MEM_EN/MEM_WB_EN=1, STALL_CNT+1.
  4. Otherwise, all enables 1 and no flush.
- MEM_WAIT:
  - All enables 0, STALL_CNT+1 every cycle, wait_cnt+1.
  - BEQ_WRONG_PRED in this state sets redirect_pending.
  - On DMEM_READY: enables are released in that same cycle. If redirect_pending, the redirect and flush actions of RUN rule 2 are applied in that cycle, FLUSH_CNT+1, and pending is cleared. Next state is RUN.
  - If wait_cnt reaches TIMEOUT with DMEM_READY=0: go to ERROR and set MEM_TIMEOUT_ERR.
  - DMEM_READY on the exact TIMEOUT cycle counts as success.
- ERROR: all enables 0 and no flush. The state is held until RST.
- A zero-wait access (DMEM_REQ & DMEM_READY in RUN) never leaves RUN.
- Counters saturate at all-ones and do not wrap. wait_cnt is $clog2(TIMEOUT+1) bits wide.

Decomposition:
- Package pipeline_pkg:
  - enum ctrl_state_t {RUN, MEM_WAIT, ERROR}
  - the stage-control struct {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_sel_redirect}, shared with the datapath top
  - beq_op constant 7'b1100011
- One natural sub-module: sat_counter (parameterised width, inc, synchronous clear, asynchronous RST), instantiated twice for STALL_CNT and FLUSH_CNT.

Test Plan:
- Reset then idle: RST high 3 cycles then low. All outputs are 0 during reset, every enable is 1 from the first post-reset cycle, counters stay 0.
- Load-use: LOAD_USE_STALL=1 for 1 cycle. That cycle PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1. STALL_CNT goes 0→1 and the next cycle returns to all enables 1.
- Mispredict plus load-use in the same cycle: PC_SEL_REDIRECT=1, both flushes=1, PC_EN=1. FLUSH_CNT=1 and STALL_CNT=0.
- Memory wait with a buried mispredict:
  - DMEM_REQ=1 with DMEM_READY=0 for 4 cycles, BEQ_WRONG_PRED pulsed in wait cycle 2, then DMEM_READY=1.
  - Required: 4 frozen cycles, then one cycle with redirect and both flushes.
  - STALL_CNT=4, FLUSH_CNT=1, state back to RUN.
- Watchdog: TIMEOUT=8, DMEM_READY held 0. MEM_TIMEOUT_ERR rises after 8 wait cycles and enables stay 0 for 20 more cycles. Asserting RST clears the error and restores RUN.
- Saturation: CNT_W=4 with 20 load-use cycles. STALL_CNT holds at 15.
